// File: rtl/reg_disp_scanner.sv
// Register-file display scanner: manual or timed round-robin selection of one
// tapped register, with an optional frozen snapshot. `DISP_CHANGE_FLAG_EN adds disp_changed.
module reg_disp_scanner #(
  parameter int NREG  = 16,
  parameter int W     = 16,
  parameter int SELW  = 4,
  parameter int DWELL = 50000000
) (
  input  logic              boardclk,
  input  logic              rst,
  input  logic [NREG*W-1:0] reg_flat,
  input  logic [SELW-1:0]   show,
  input  logic              auto_en,
  input  logic              freeze,
  output logic [W-1:0]      disp,
  output logic [SELW-1:0]   disp_idx,
  output logic              disp_valid,
  output logic              step_pulse
`ifdef DISP_CHANGE_FLAG_EN
  ,
  output logic              disp_changed
`endif
);

  localparam int NSLOT = 2 ** SELW;
  localparam int CW    = $clog2(DWELL);

  localparam logic [SELW:0] NREG_L     = (SELW + 1)'(NREG);
  localparam logic [SELW:0] LAST_L     = (SELW + 1)'(NREG - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic {MANUAL, AUTO} idx_state_t;
  typedef enum logic {LIVE, HELD}   cap_state_t;

  idx_state_t idx_state, idx_state_nx;
  cap_state_t cap_state, cap_state_nx;

  logic [SELW-1:0] idx, idx_nx, idx_wrap;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            step_nx;
  logic            idx_valid, nx_valid;
  logic            capture, use_snap;
  logic [W-1:0]    disp_nx;

  logic [W-1:0] snap   [NREG];
  logic [W-1:0] live_v [NSLOT];
  logic [W-1:0] snap_v [NSLOT];

  // ---------------------------------------------------------------------------
  // State register (both FSMs plus scan position and dwell counter)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge boardclk or negedge rst) begin
    if (!rst) begin
      idx_state <= MANUAL;
      cap_state <= LIVE;
      idx       <= '0;
      cnt       <= '0;
    end else begin
      idx_state <= idx_state_nx;
      cap_state <= cap_state_nx;
      idx       <= idx_nx;
      cnt       <= cnt_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    idx_state_nx = idx_state;
    unique case (idx_state)
      MANUAL: if (auto_en)  idx_state_nx = AUTO;
      AUTO:   if (!auto_en) idx_state_nx = MANUAL;
    endcase
  end

  always_comb begin
    cap_state_nx = freeze ? HELD : LIVE;
  end

  // ---------------------------------------------------------------------------
  // FSM outputs: next index, dwell count and step request
  // ---------------------------------------------------------------------------
  assign idx_valid = ({1'b0, idx} < NREG_L);
  assign idx_wrap  = ({1'b0, idx} == LAST_L) ? '0 : idx + 1'b1;

  always_comb begin
    idx_nx  = idx;
    cnt_nx  = '0;
    step_nx = 1'b0;
    unique case (idx_state)
      MANUAL: begin
        // Entering the scan keeps the current position unless it is unusable.
        if (auto_en) idx_nx = idx_valid ? idx : '0;
        else         idx_nx = show;
      end
      AUTO: begin
        if (!auto_en) begin
          idx_nx = show;
        end else if (cnt == DWELL_LAST) begin
          idx_nx  = idx_wrap;
          step_nx = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Snapshot capture
  // ---------------------------------------------------------------------------
  assign capture  = (cap_state == LIVE) && freeze;
  // On the capture edge the snapshot equals this edge's reg_flat, so live data
  // is the right source for that one cycle.
  assign use_snap = (cap_state == HELD) && freeze;

  // NOTE: the snapshot is a small register bank, not a RAM, so it is reset
  // with everything else; a stale frozen set must never survive a reset.
  always_ff @(posedge boardclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) snap[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < NREG; i++) snap[i] <= reg_flat[i*W +: W];
    end
  end

  // Index-addressable views padded to the full index range; unused slots
  // read as zero, which gives the out-of-range display for free.
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NREG) begin : g_on
      assign live_v[i] = reg_flat[i*W +: W];
      assign snap_v[i] = snap[i];
    end else begin : g_off
      assign live_v[i] = '0;
      assign snap_v[i] = '0;
    end
  end

  assign nx_valid = ({1'b0, idx_nx} < NREG_L);
  assign disp_nx  = use_snap ? snap_v[idx_nx] : live_v[idx_nx];

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge boardclk or negedge rst) begin
    if (!rst) begin
      disp       <= '0;
      disp_valid <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      disp       <= disp_nx;
      disp_valid <= nx_valid;
      step_pulse <= step_nx;
    end
  end

  assign disp_idx = idx;

`ifdef DISP_CHANGE_FLAG_EN
  always_ff @(posedge boardclk or negedge rst) begin
    if (!rst) disp_changed <= 1'b0;
    else      disp_changed <= (disp_nx != disp);
  end
`endif

  // An advance always lands on a real register, and invalid slots show zero.
  a_step_valid : assert property (@(posedge boardclk) disable iff (!rst)
    step_pulse |-> disp_valid);
  a_invalid_zero : assert property (@(posedge boardclk) disable iff (!rst)
    !disp_valid |-> (disp == '0));

endmodule

// File: tb/tb_reg_disp_scanner.sv
// Scoreboard bench for reg_disp_scanner: the driver pushes model predictions,
// a monitor pops and compares once per clock after the DUT updates.
module tb_reg_disp_scanner;

  localparam int NREG  = 10;
  localparam int W     = 16;
  localparam int SELW  = 4;
  localparam int DWELL = 4;

  logic              boardclk = 1'b0;
  logic              rst      = 1'b0;
  logic [NREG*W-1:0] reg_flat;
  logic [SELW-1:0]   show     = '0;
  logic              auto_en  = 1'b0;
  logic              freeze   = 1'b0;
  logic [W-1:0]      disp;
  logic [SELW-1:0]   disp_idx;
  logic              disp_valid;
  logic              step_pulse;
`ifdef DISP_CHANGE_FLAG_EN
  logic              disp_changed;
`endif

  logic [W-1:0] regs [NREG];

  always_comb begin
    reg_flat = '0;
    for (int i = 0; i < NREG; i++) reg_flat[i*W +: W] = regs[i];
  end

  reg_disp_scanner #(.NREG(NREG), .W(W), .SELW(SELW), .DWELL(DWELL)) dut (
    .boardclk   (boardclk),
    .rst        (rst),
    .reg_flat   (reg_flat),
    .show       (show),
    .auto_en    (auto_en),
    .freeze     (freeze),
    .disp       (disp),
    .disp_idx   (disp_idx),
    .disp_valid (disp_valid),
    .step_pulse (step_pulse)
`ifdef DISP_CHANGE_FLAG_EN
    ,
    .disp_changed (disp_changed)
`endif
  );

  always #5 boardclk = ~boardclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int    disp;
    int    idx;
    bit    valid;
    bit    step;
    bit    changed;
    string tag;
  } exp_t;

  exp_t sbq[$];

  // Behavioural model: scan mode, position, dwell elapsed, frozen copy.
  bit m_auto, m_held;
  int m_idx, m_dwell, m_prev;
  int m_snap [NREG];

  task automatic model_reset();
    m_auto  = 1'b0;
    m_held  = 1'b0;
    m_idx   = 0;
    m_dwell = 0;
    m_prev  = 0;
    for (int i = 0; i < NREG; i++) m_snap[i] = 0;
  endtask

  // Drive one cycle of inputs (regs already set by caller), predict the
  // outputs after the next rising edge, then move on to the next falling edge.
  task automatic apply(input int s, input bit a, input bit f, input string tag);
    exp_t e;
    int   val;
    bit   st;
    show    = SELW'(s);
    auto_en = a;
    freeze  = f;
    st      = 1'b0;
    if (!m_auto) begin
      if (a) begin
        m_auto  = 1'b1;
        m_dwell = 0;
        if (m_idx >= NREG) m_idx = 0;
      end else begin
        m_idx = s;
      end
    end else if (!a) begin
      m_auto  = 1'b0;
      m_dwell = 0;
      m_idx   = s;
    end else if (m_dwell == DWELL - 1) begin
      m_dwell = 0;
      m_idx   = (m_idx + 1) % NREG;
      st      = 1'b1;
    end else begin
      m_dwell++;
    end
    if (f && !m_held)
      for (int i = 0; i < NREG; i++) m_snap[i] = int'(regs[i]);
    m_held = f;
    if (m_idx < NREG) val = m_held ? m_snap[m_idx] : int'(regs[m_idx]);
    else              val = 0;
    e.disp    = val;
    e.idx     = m_idx;
    e.valid   = (m_idx < NREG);
    e.step    = st;
    e.changed = (val != m_prev);
    e.tag     = tag;
    m_prev    = val;
    sbq.push_back(e);
    @(negedge boardclk);
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check({tag, ".disp"},  disp,       0);
    check({tag, ".idx"},   disp_idx,   0);
    check({tag, ".valid"}, disp_valid, 0);
    check({tag, ".step"},  step_pulse, 0);
`ifdef DISP_CHANGE_FLAG_EN
    check({tag, ".chg"},   disp_changed, 0);
`endif
    @(negedge boardclk);
    check({tag, ".held_disp"}, disp, 0);
    rst = 1'b1;
    model_reset();
  endtask

  // Monitor: one output sample per clock, taken just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge boardclk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check({e.tag, ".disp"},  disp,       e.disp);
        check({e.tag, ".idx"},   disp_idx,   e.idx);
        check({e.tag, ".valid"}, disp_valid, e.valid);
        check({e.tag, ".step"},  step_pulse, e.step);
`ifdef DISP_CHANGE_FLAG_EN
        check({e.tag, ".chg"},   disp_changed, e.changed);
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit a, f;
    for (int i = 0; i < NREG; i++) regs[i] = '0;
    #2;
    do_reset("reset0");

    // Manual selection.
    for (int i = 0; i < NREG; i++) regs[i] = W'(i * 100 + 7);
    apply(3, 0, 0, "t1_show3");
    apply(9, 0, 0, "t1_show9");

    // Out-of-range index.
    apply(12, 0, 0, "t2_show12");
    apply(0, 0, 0, "t2_show0");

    // Auto scan from 8, wrapping 9 -> 0, then back to manual.
    apply(8, 0, 0, "t3_pre");
    for (int i = 0; i < 14; i++) apply(1, 1, 0, "t3_auto");
    apply(5, 0, 0, "t3_exit");
    apply(5, 0, 0, "t3_man");

    // Freeze holds 207 while the live value moves to 555; fresh re-freeze.
    apply(2, 0, 1, "t4_frz");
    regs[2] = W'(555);
    apply(2, 0, 1, "t4_held");
    apply(2, 0, 1, "t4_held2");
    apply(2, 0, 0, "t4_live");
    apply(2, 0, 1, "t4_refrz");
    regs[2] = W'(1);
    apply(2, 0, 1, "t4_reheld");
    apply(2, 0, 0, "t4_relive");

    // Freeze and auto on the same edge while every register churns.
    apply(7, 0, 0, "t5_pre");
    for (int c = 0; c < 30; c++) begin
      for (int i = 0; i < NREG; i++) regs[i] = W'($urandom);
      apply($urandom_range(15, 0), 1, 1, "t5_scan");
    end
    do_reset("t5_rst");

    // Stable source, then a single change of the shown register.
    for (int i = 0; i < NREG; i++) regs[i] = W'(i * 100 + 7);
    apply(4, 0, 0, "t6_a");
    apply(4, 0, 0, "t6_b");
    apply(4, 0, 0, "t6_c");
    regs[4] = regs[4] + 1'b1;
    apply(4, 0, 0, "t6_chg");
    apply(4, 0, 0, "t6_after");

    // Randomised soak with slow-changing mode levels.
    a = 1'b0;
    f = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(11, 0) == 0) a = ~a;
      if ($urandom_range(9, 0) == 0)  f = ~f;
      if ($urandom_range(2, 0) == 0)
        regs[$urandom_range(NREG - 1, 0)] = W'($urandom);
      apply($urandom_range(15, 0), a, f, "rand");
      if (c == 200) do_reset("rand_rst");
    end

    @(negedge boardclk);
    @(negedge boardclk);
    check("drain.pending", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
